// File: rtl/sum_series_pkg.sv
// rtl/sum_series_pkg.sv - shared FP32 constants, FSM state type and leading-zero helper
package sum_series_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    // Leading-zero count of a 27-bit mantissa with guard/round/sticky (27 when zero).
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) begin
                lzc27 = 5'(26 - i);
            end
        end
    endfunction

endpackage

// File: rtl/fp32_add.sv
// rtl/fp32_add.sv - combinational binary32 adder, round-to-nearest-even, flush-to-zero
// Ports:
//   a, b : binary32 operands
//   y    : binary32 sum
module fp32_add
    import sum_series_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign sa = a[31];
    assign sb = b[31];
    assign ea = a[MAN_W +: EXP_W];
    assign eb = b[MAN_W +: EXP_W];
    assign fa = a[MAN_W-1:0];
    assign fb = b[MAN_W-1:0];

    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    // Denormals have a zero exponent and are treated as zero.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);

    logic              a_big, s_big;
    logic [7:0]        e_big, e_sml, d;
    logic [26:0]       m_big, m_sml, m_sh, lost;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic [26:0]       m_norm;
    logic signed [9:0] e_norm, e_fin;
    logic              rnd;
    logic [24:0]       m_rnd;
    logic [22:0]       frac;

    always_comb begin
        a_big  = ({ea, fa} >= {eb, fb});
        s_big  = a_big ? sa : sb;
        e_big  = a_big ? ea : eb;
        e_sml  = a_big ? eb : ea;
        // Layout: hidden bit, 23 fraction bits, guard, round, sticky.
        m_big  = {1'b1, (a_big ? fa : fb), 3'b000};
        m_sml  = {1'b1, (a_big ? fb : fa), 3'b000};
        d      = e_big - e_sml;
        lost   = '0;
        if (d >= 8'd27) begin
            m_sh = 27'd1;
        end else begin
            m_sh    = m_sml >> d[4:0];
            lost    = m_sml & ((27'd1 << d[4:0]) - 27'd1);
            m_sh[0] = m_sh[0] | (|lost);
        end

        // The larger magnitude is always the minuend, so the difference is non-negative.
        if (sa ^ sb) begin
            sum = {1'b0, m_big} - {1'b0, m_sh};
        end else begin
            sum = {1'b0, m_big} + {1'b0, m_sh};
        end

        lz = lzc27(sum[26:0]);
        if (sum[27]) begin
            m_norm = {sum[27:2], sum[1] | sum[0]};
            e_norm = $signed({2'b00, e_big}) + 10'sd1;
        end else begin
            m_norm = sum[26:0] << lz;
            e_norm = $signed({2'b00, e_big}) - $signed({5'b00000, lz});
        end

        rnd   = m_norm[2] & (m_norm[1] | m_norm[0] | m_norm[3]);
        m_rnd = {1'b0, m_norm[26:3]} + {24'd0, rnd};
        // Rounding carry-out leaves a power of two: bump the exponent, fraction becomes zero.
        e_fin = m_rnd[24] ? e_norm + 10'sd1 : e_norm;
        frac  = m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0];

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            y = QNAN;
        end else if (a_inf) begin
            y = {sa, POS_INF[30:0]};
        end else if (b_inf) begin
            y = {sb, POS_INF[30:0]};
        end else if (a_zero && b_zero) begin
            y = {sa & sb, 31'd0};
        end else if (a_zero) begin
            y = b;
        end else if (b_zero) begin
            y = a;
        end else if (sum == '0) begin
            y = 32'h00000000;
        end else if (e_fin < 10'sd1) begin
            y = {s_big, 31'd0};
        end else if (e_fin > $signed(10'(2 * BIAS))) begin
            y = {s_big, POS_INF[30:0]};
        end else begin
            y = {s_big, e_fin[7:0], frac};
        end
    end

endmodule

// File: rtl/sum_series.sv
// rtl/sum_series.sv - sequential binary32 accumulator over an N-element array
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset
//   start      : run request, level-sampled in IDLE
//   data_array : N binary32 operands, stable from start until done
//   sum_output : accumulator (final sum valid while done)
//   done       : registered run-complete flag
module sum_series
    import sum_series_pkg::*;
#(
    parameter int N          = 100,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_array [0:N-1],
    output logic [DATA_WIDTH-1:0] sum_output,
    output logic                  done
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $fatal(1, "sum_series: DATA_WIDTH must be 32");
    end
    if (N < 1) begin : g_bad_n
        $fatal(1, "sum_series: N must be at least 1");
    end

    localparam int IW = $clog2(N) + 1;

    state_t                state, state_next;
    logic [IW-1:0]         index, index_next;
    logic [DATA_WIDTH-1:0] acc, acc_next, elem, add_y;
    logic                  done_next;

    // Explicit mux keeps the index width independent of the array bounds.
    always_comb begin
        elem = '0;
        for (int i = 0; i < N; i++) begin
            if (index == IW'(i)) begin
                elem = data_array[i];
            end
        end
    end

    fp32_add u_add (
        .a (acc),
        .b (elem),
        .y (add_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            index <= '0;
            acc   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            index <= index_next;
            acc   <= acc_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        index_next = index;
        acc_next   = acc;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACCUM;
                    index_next = '0;
                    acc_next   = '0;
                end
            end
            ACCUM: begin
                acc_next   = add_y;
                index_next = index + IW'(1);
                if (index == IW'(N - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // done trails the state by one register stage.
                done_next = 1'b1;
                if (!start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sum_output = acc;

endmodule

// File: tb/tb_sum_series.sv
// tb/tb_sum_series.sv - randomized and directed bench for sum_series against an exact-arithmetic model
module tb_sum_series;

    localparam int N = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] arr [0:N-1];
    logic [31:0] sum_output;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sum_series #(.N(N), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .data_array (arr),
        .sum_output (sum_output),
        .done       (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Exact sum as a scaled integer, then rounded to 24 significant bits (ties to even).
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, elo, sh, p, e;
        longint va, vb, tot, mag, q, rem, half;
        logic s;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
        if (ea == 255 && eb == 255) return (a[31] != b[31]) ? 32'h7FC00000 : a;
        if (ea == 255) return {a[31], 31'h7F800000};
        if (eb == 255) return {b[31], 31'h7F800000};
        if (ea == 0 && eb == 0) return {a[31] & b[31], 31'd0};
        if (ea == 0) return b;
        if (eb == 0) return a;
        if (ea - eb >= 26) return a;
        if (eb - ea >= 26) return b;
        elo = (ea < eb) ? ea : eb;
        va  = longint'({1'b1, a[22:0]}) << (ea - elo);
        vb  = longint'({1'b1, b[22:0]}) << (eb - elo);
        if (a[31]) va = -va;
        if (b[31]) vb = -vb;
        tot = va + vb;
        if (tot == 0) return 32'h00000000;
        s   = (tot < 0);
        mag = s ? -tot : tot;
        p   = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) p = i;
        sh = p - 23;
        if (p > 23) begin
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 64'sd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'sd1 << 24)) begin
                q  = q >> 1;
                sh = sh + 1;
            end
        end else begin
            q = mag << (23 - p);
        end
        e = elo + sh;
        if (e < 1) return {s, 31'd0};
        if (e > 254) return {s, 31'h7F800000};
        return {s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] ref_sum();
        logic [31:0] t;
        t = 32'h00000000;
        for (int i = 0; i < N; i++) t = ref_add(t, arr[i]);
        return t;
    endfunction

    task automatic fill_const(input logic [31:0] v);
        for (int i = 0; i < N; i++) arr[i] = v;
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 15) == 0) arr[i] = 32'h00000000;
            else arr[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(lo, hi)), 23'($urandom)};
        end
    endtask

    // Must be called just after a falling edge with the FSM in IDLE.
    task automatic do_run(input string tag, input logic [31:0] expv);
        int cyc;
        cyc   = 0;
        start = 1'b1;
        @(posedge clk);
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!done && cyc < 400);
        check_eq({tag, "_latency"}, 32'(cyc), 32'(N + 1));
        check_eq({tag, "_sum"}, sum_output, expv);
    endtask

    task automatic go_idle(input string tag);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!done) break;
        end
        check_eq({tag, "_done_low"}, 32'(done), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fill_const(32'h00000000);
        #7;
        check_eq("reset_sum", sum_output, 32'h00000000);
        check_eq("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        fill_const(32'h3F800000);
        do_run("ones", 32'h42C80000);
        repeat (5) @(negedge clk);
        check_eq("ones_hold_done", 32'(done), 32'd1);
        check_eq("ones_hold_sum", sum_output, 32'h42C80000);
        go_idle("ones");

        fill_const(32'h40000000);
        do_run("twos", 32'h43480000);
        go_idle("twos");

        fill_const(32'h40A9999A);
        do_run("five3", ref_sum());
        go_idle("five3");

        for (int i = 0; i < N; i++) arr[i] = i[0] ? 32'hC0200000 : 32'h40200000;
        do_run("alt", 32'h00000000);
        go_idle("alt");

        fill_const(32'h00000000);
        arr[0] = 32'h7F7FFFFF;
        arr[1] = 32'h7F7FFFFF;
        do_run("ovf", 32'h7F800000);
        go_idle("ovf");

        fill_const(32'h00000000);
        arr[5] = 32'h7F800001;
        do_run("nan", 32'h7FC00000);
        go_idle("nan");

        fill_const(32'h3F800000);
        start = 1'b1;
        @(posedge clk);
        repeat (40) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_sum", sum_output, 32'h00000000);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_idle_done", 32'(done), 32'd0);
        do_run("after_abort", 32'h42C80000);
        go_idle("after_abort");

        for (int r = 0; r < 6; r++) begin
            if (r < 3) fill_rand(110, 140);
            else fill_rand(125, 129);
            do_run($sformatf("rand%0d", r), ref_sum());
            go_idle($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sum_series.md
Name: sum_series

Overview:
- Sequential accumulator that sums an array of N IEEE-754 single-precision floats. It adds one element per clock into a running floating-point total.
- A start pulse launches a run. When the run completes, done is raised and the total is presented on sum_output.
- Used as a compute leaf. The array is driven in parallel by the surrounding logic or bench.

Parameters:
- N, 100, number of array elements to sum. Legal values are N >= 1.
- DATA_WIDTH, 32, element and result width. Only 32 (IEEE-754 binary32) is supported; elaborate with a fatal error for any other value.

Ports:
- clk  input  1  single clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- start  input  1  launch request, level-sampled in IDLE
- data_array  input  N x DATA_WIDTH (unpacked array [0:N-1])  binary32 operands; must be held stable from start until done
- sum_output  output  DATA_WIDTH  binary32 running/final sum (accumulator register)
- done  output  1  high while the final sum is valid

Behaviour:
- Reset: asynchronous, active-high. While reset is high:
  - state = IDLE, index = 0
  - accumulator = 0x00000000, so sum_output = 0x00000000
  - done = 0
- Reset mid-run aborts the run immediately. No done is produced.
- FSM states are IDLE, ACCUM and DONE.
- IDLE:
  - done = 0.
  - If start = 1 at a rising edge: accumulator <= +0.0, index <= 0, go to ACCUM.
- ACCUM:
  - Each cycle: accumulator <= fp_add(accumulator, data_array[index]), index <= index + 1.
  - On the cycle that adds element N-1, go to DONE.
  - start is ignored in this state.
- DONE:
  - done = 1 (registered). sum_output holds the final sum.
  - Stay in DONE while start = 1. When start = 0, return to IDLE.
  - A new run therefore needs start to go low and then high again.
- Latency: start sampled at edge k, so done is high after edge k+N+1. The run has exactly N add cycles.
- Summation order is index 0 to N-1, strictly sequential. The result is the rounded left-to-right sum, not the exact sum.
- The adder (fp_add) is combinational, single-cycle binary32 addition:
  - Operands are aligned with guard/round/sticky bits. Rounding is round-to-nearest-even.
  - The result is renormalised after the add. The path must handle cancellation and the carry-out shift.
  - Denormal inputs are treated as zero (same sign). Results with an exponent below 1 are flushed to signed zero.
  - Exponent overflow returns ±Inf (0x7F800000 / 0xFF800000).
  - Any NaN input, or +Inf plus -Inf, returns canonical NaN 0x7FC00000.
  - Inf plus a finite value returns that Inf.
  - An exact zero result is +0.0, except (-0) + (-0) = -0.
- sum_output shows intermediate partial sums during ACCUM. It is only architecturally valid while done = 1.
- index width is $clog2(N)+1 bits, so it never wraps before N.

Decomposition:
- Package sum_series_pkg holds:
  - FP32 field constants: EXP_W = 8, MAN_W = 23, BIAS = 127
  - QNAN = 32'h7FC00000, POS_INF = 32'h7F800000
  - the state enum typedef (IDLE, ACCUM, DONE)
- One sub-module, fp32_add: combinational, with inputs a and b, output y. Its behaviour is the adder rules listed under Behaviour.
- The top level sum_series holds the FSM, the index counter and the accumulator register.

Test Plan:
- All 100 elements = 0x3F800000 (1.0), reset for 10 ns, then start = 1 and held → done rises 101 cycles after the start edge; sum_output = 0x42C80000 (100.0). While start stays high, done and sum_output hold.
- All 100 elements = 0x40A9999A (5.3), start held high → done = 1; sum_output within 1e-4 relative of 530.0 (0x44048000); bit-exact against a sequential binary32 RNE reference model.
- Alternating +2.5 (0x40200000) and -2.5 (0xC0200000), N = 100 → sum_output = 0x00000000 (+0.0) at done.
- Element 0 = 0x7F7FFFFF (max finite), element 1 = 0x7F7FFFFF, rest 0 → sum_output = 0x7F800000 (+Inf). Element 5 = NaN 0x7F800001 → 0x7FC00000.
- Assert reset mid-ACCUM (cycle 40) → done = 0, sum_output = 0 immediately. After release, the next start gives a correct full-run result.
- Two back-to-back runs: start dropped after done, then raised again with a new array (all 0x40000000, 2.0) → done falls in IDLE, then rises again with 0x43480000 (200.0).
